// File: rtl/alu_csr_datapath_if.sv
// rtl/alu_csr_datapath_if.sv - CSR access bus between the core control slice and the CSR file
interface alu_csr_datapath_if;
    logic        csr_write_enable;
    logic [11:0] csr_address;
    logic [4:0]  csr_immediate;
    logic [31:0] csr_data_in;
    logic [31:0] csr_data_out;

    modport master (
        output csr_write_enable, csr_address, csr_immediate, csr_data_in,
        input  csr_data_out
    );

    modport slave (
        input  csr_write_enable, csr_address, csr_immediate, csr_data_in,
        output csr_data_out
    );
endinterface

// File: rtl/alu_csr_datapath.sv
// rtl/alu_csr_datapath.sv - RV32I ALU, ALU-op decoder and machine-mode CSR file with interrupt bookkeeping
// Optional 64-bit mcycle counter at 0xB00/0xB80 (aliases 0xC00/0xC80) when CSR_COUNTERS_EN is defined.
module alu_csr_datapath #(
    parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_immediate,
    input  logic [1:0]                aluop_in,
    input  logic [6:0]                func7,
    input  logic [2:0]                func3,
    input  logic                      alu_input_selector,
    input  logic [3:0]                control_unit_aluop,
    input  logic [31:0]               alu_in_x,
    input  logic [31:0]               alu_in_y,
    output logic [31:0]               alu_out,
    output logic                      zero,
    alu_csr_datapath_if.slave         csr_bus,
    input  logic [31:0]               pc_value,
    input  logic                      trap_enter,
    input  logic                      mret,
    input  logic                      interruption_request_external,
    input  logic                      interruption_request_timer,
    input  logic                      interruption_request_software,
    input  logic [15:0]               interruption_request_fast,
    output logic                      interrupt_pending,
    output logic [31:0]               trap_target
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,  OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
        OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_EQ   = 4'd10, OP_NE   = 4'd11,
        OP_LT   = 4'd12, OP_GE   = 4'd13, OP_LTU  = 4'd14, OP_GEU  = 4'd15
    } alu_op_e;

    alu_op_e     alu_op;
    logic [31:0] alu_result;
    logic        branch_cond;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [4:0]  shamt;

    always_comb begin
        alu_op = OP_ADD;
        if (alu_input_selector) begin
            alu_op = alu_op_e'(control_unit_aluop);
        end else begin
            case (aluop_in)
                2'b01: begin
                    case (func3)
                        3'b001:  alu_op = OP_NE;
                        3'b100:  alu_op = OP_LT;
                        3'b101:  alu_op = OP_GE;
                        3'b110:  alu_op = OP_LTU;
                        3'b111:  alu_op = OP_GEU;
                        default: alu_op = OP_EQ;
                    endcase
                end
                2'b10: begin
                    case (func3)
                        3'b000:  alu_op = (!is_immediate && func7[5]) ? OP_SUB : OP_ADD;
                        3'b001:  alu_op = OP_SLL;
                        3'b010:  alu_op = OP_SLT;
                        3'b011:  alu_op = OP_SLTU;
                        3'b100:  alu_op = OP_XOR;
                        3'b101:  alu_op = func7[5] ? OP_SRA : OP_SRL;
                        3'b110:  alu_op = OP_OR;
                        default: alu_op = OP_AND;
                    endcase
                end
                default: alu_op = OP_ADD;
            endcase
        end
    end

    assign shamt       = alu_in_y[4:0];
    assign lt_signed   = $signed(alu_in_x) < $signed(alu_in_y);
    assign lt_unsigned = alu_in_x < alu_in_y;

    always_comb begin
        alu_result  = 32'd0;
        branch_cond = 1'b0;
        case (alu_op)
            OP_ADD:  alu_result = alu_in_x + alu_in_y;
            OP_SUB:  alu_result = alu_in_x - alu_in_y;
            OP_SLL:  alu_result = alu_in_x << shamt;
            OP_SLT:  alu_result = {31'd0, lt_signed};
            OP_SLTU: alu_result = {31'd0, lt_unsigned};
            OP_XOR:  alu_result = alu_in_x ^ alu_in_y;
            OP_SRL:  alu_result = alu_in_x >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(alu_in_x) >>> shamt);
            OP_OR:   alu_result = alu_in_x | alu_in_y;
            OP_AND:  alu_result = alu_in_x & alu_in_y;
            OP_EQ:   branch_cond = (alu_in_x == alu_in_y);
            OP_NE:   branch_cond = (alu_in_x != alu_in_y);
            OP_LT:   branch_cond = lt_signed;
            OP_GE:   branch_cond = !lt_signed;
            OP_LTU:  branch_cond = lt_unsigned;
            default: branch_cond = !lt_unsigned;
        endcase
        // Branch compares report their outcome on both alu_out and zero.
        if (alu_op >= OP_EQ) begin
            alu_out = {31'd0, branch_cond};
            zero    = branch_cond;
        end else begin
            alu_out = alu_result;
            zero    = (alu_result == 32'd0);
        end
    end

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
`endif

    logic [31:0] mip;
    logic [31:0] mstatus_val;
    logic [31:0] irq_vec;
    logic [4:0]  irq_cause;
    logic [31:0] mtvec_base;
    logic [31:0] csr_rdata;
    logic [31:0] csr_src;
    logic [31:0] csr_wdata;
    logic        csr_wr;
    logic        trap_take;
    logic        unused_bits;

    assign unused_bits = ^{func7[6], func7[4:0], pc_value[1:0]};

    assign mip = {interruption_request_fast, 4'd0, interruption_request_external, 3'd0,
                  interruption_request_timer, 3'd0, interruption_request_software, 3'd0};
    assign mstatus_val       = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
    assign irq_vec           = mip & mie_q;
    assign interrupt_pending = mstatus_mie_q & (|irq_vec);
    assign trap_take         = trap_enter & interrupt_pending;

    // Fast interrupts scanned high-to-low so the lowest index wins.
    always_comb begin
        irq_cause = 5'd0;
        if (irq_vec[11]) begin
            irq_cause = 5'd11;
        end else if (irq_vec[3]) begin
            irq_cause = 5'd3;
        end else if (irq_vec[7]) begin
            irq_cause = 5'd7;
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (irq_vec[16+i]) irq_cause = 5'(16 + i);
            end
        end
    end

    assign mtvec_base  = {mtvec_q[31:2], 2'b00};
    assign trap_target = (mtvec_q[1:0] == 2'b01 && interrupt_pending)
                         ? mtvec_base + {25'd0, irq_cause, 2'b00} : mtvec_base;

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_bus.csr_address)
            12'h300: csr_rdata = mstatus_val;
            12'h301: csr_rdata = MISA_VALUE;
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = mip;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: csr_rdata = mcycle_q[31:0];
            12'hB80, 12'hC80: csr_rdata = mcycle_q[63:32];
`endif
            default: csr_rdata = 32'd0;
        endcase
    end

    assign csr_bus.csr_data_out = csr_rdata;

    assign csr_src = func3[2] ? {27'd0, csr_bus.csr_immediate} : csr_bus.csr_data_in;
    assign csr_wr  = csr_bus.csr_write_enable && (func3[1:0] != 2'b00);

    always_comb begin
        case (func3[1:0])
            2'b10:   csr_wdata = csr_rdata | csr_src;
            2'b11:   csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_src;
        endcase
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d       = mcycle_q + 64'd1;
`endif
        if (csr_wr) begin
            case (csr_bus.csr_address)
                12'h300: begin
                    mstatus_mie_d  = csr_wdata[3];
                    mstatus_mpie_d = csr_wdata[7];
                end
                12'h304: mie_d      = csr_wdata;
                12'h305: mtvec_d    = csr_wdata;
                12'h340: mscratch_d = csr_wdata;
                12'h341: mepc_d     = {csr_wdata[31:2], 2'b00};
                12'h342: mcause_d   = csr_wdata;
                12'h343: mtval_d    = csr_wdata;
`ifdef CSR_COUNTERS_EN
                12'hB00: mcycle_d[31:0]  = csr_wdata;
                12'hB80: mcycle_d[63:32] = csr_wdata;
`endif
                default: ;
            endcase
        end
        // A taken trap overrides both a same-cycle CSR write and mret.
        if (trap_take) begin
            mepc_d         = {pc_value[31:2], 2'b00};
            mcause_d       = {1'b1, 26'd0, irq_cause};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= 32'd0;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
`ifdef CSR_COUNTERS_EN
            mcycle_q       <= 64'd0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q       <= mcycle_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_csr_datapath.sv
// tb/tb_alu_csr_datapath.sv - scoreboard bench for alu_csr_datapath with a behavioural reference model
module tb_alu_csr_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        is_immediate = 1'b0;
    logic [1:0]  aluop_in = 2'b00;
    logic [6:0]  func7 = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic        alu_input_selector = 1'b0;
    logic [3:0]  control_unit_aluop = 4'd0;
    logic [31:0] alu_in_x = 32'd0, alu_in_y = 32'd0;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] pc_value = 32'd0;
    logic        trap_enter = 1'b0, mret = 1'b0;
    logic        irq_ext = 1'b0, irq_tmr = 1'b0, irq_sw = 1'b0;
    logic [15:0] irq_fast = 16'd0;
    logic        interrupt_pending;
    logic [31:0] trap_target;

    alu_csr_datapath_if bus ();

    always #5 clk = ~clk;

    alu_csr_datapath dut (
        .clk(clk), .reset(reset),
        .is_immediate(is_immediate), .aluop_in(aluop_in), .func7(func7), .func3(func3),
        .alu_input_selector(alu_input_selector), .control_unit_aluop(control_unit_aluop),
        .alu_in_x(alu_in_x), .alu_in_y(alu_in_y), .alu_out(alu_out), .zero(zero),
        .csr_bus(bus),
        .pc_value(pc_value), .trap_enter(trap_enter), .mret(mret),
        .interruption_request_external(irq_ext), .interruption_request_timer(irq_tmr),
        .interruption_request_software(irq_sw), .interruption_request_fast(irq_fast),
        .interrupt_pending(interrupt_pending), .trap_target(trap_target)
    );

    typedef struct {
        int          tag;
        logic [31:0] alu;
        logic        zf;
        logic [31:0] csr;
        logic        pend;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   tag_n  = 0;

    // Reference architectural state
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cycle;

    logic [3:0]  br_tab  [0:7] = '{4'd10, 4'd11, 4'd10, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [3:0]  ar_tab  [0:7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [11:0] addr_tab[0:16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'hF11, 12'hF14, 12'hB00,
                                    12'hB80, 12'hC00, 12'hC80, 12'h123, 12'h7FF};

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s tag=%0d got=%h expected=%h", name, tag, act, exp);
    endtask

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0;
        m_ie = 0; m_tvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
        m_cycle = 0;
    endfunction

    function automatic logic [3:0] ref_op();
        logic [3:0] op;
        if (alu_input_selector) return control_unit_aluop;
        if (aluop_in == 2'b01) return br_tab[func3];
        if (aluop_in != 2'b10) return 4'd0;
        op = ar_tab[func3];
        if (func3 == 3'd0 && !is_immediate && func7[5]) op = 4'd1;
        if (func3 == 3'd5 && func7[5]) op = 4'd7;
        return op;
    endfunction

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic z);
        int signed sx, sy;
        sx = x; sy = y;
        case (op)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x << y[4:0];
            4'd3:  r = (sx < sy) ? 1 : 0;
            4'd4:  r = (x < y) ? 1 : 0;
            4'd5:  r = x ^ y;
            4'd6:  r = x >> y[4:0];
            4'd7:  r = sx >>> y[4:0];
            4'd8:  r = x | y;
            4'd9:  r = x & y;
            4'd10: r = (x == y) ? 1 : 0;
            4'd11: r = (x != y) ? 1 : 0;
            4'd12: r = (sx < sy) ? 1 : 0;
            4'd13: r = (sx >= sy) ? 1 : 0;
            4'd14: r = (x < y) ? 1 : 0;
            default: r = (x >= y) ? 1 : 0;
        endcase
        z = (op >= 4'd10) ? r[0] : (r == 0);
    endfunction

    function automatic logic [31:0] ref_mip();
        return (32'(irq_fast) << 16) | (32'(irq_ext) << 11) | (32'(irq_tmr) << 7) | (32'(irq_sw) << 3);
    endfunction

    function automatic logic [31:0] ref_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h301: return 32'h40000100;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return ref_mip();
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_pending();
        return m_mie && ((ref_mip() & m_ie) != 0);
    endfunction

    function automatic int ref_cause();
        int order[$];
        logic [31:0] act;
        order = '{11, 3, 7};
        for (int i = 16; i < 32; i++) order.push_back(i);
        act = ref_mip() & m_ie;
        foreach (order[k]) if (act[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic logic [31:0] ref_target();
        logic [31:0] base;
        base = m_tvec & ~32'h3;
        if (m_tvec[1:0] == 2'b01 && ref_pending()) return base + 4 * ref_cause();
        return base;
    endfunction

    // State update for the rising edge that just happened, using the inputs held across it.
    function automatic void commit();
        bit          take, old_mie, old_mpie;
        int          cause;
        logic [31:0] src, nv;
        take = trap_enter && ref_pending();
        cause = ref_cause();
        old_mie = m_mie; old_mpie = m_mpie;
        nv = 0;
        m_cycle = m_cycle + 1;
        if (bus.csr_write_enable && func3[1:0] != 2'b00) begin
            src = func3[2] ? 32'(bus.csr_immediate) : bus.csr_data_in;
            case (func3[1:0])
                2'b01: nv = src;
                2'b10: nv = ref_read(bus.csr_address) | src;
                default: nv = ref_read(bus.csr_address) & ~src;
            endcase
            case (bus.csr_address)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_ie = nv;
                12'h305: m_tvec = nv;
                12'h340: m_scratch = nv;
                12'h341: m_epc = nv & ~32'h3;
                12'h342: m_cause = nv;
                12'h343: m_tval = nv;
`ifdef CSR_COUNTERS_EN
                12'hB00: m_cycle[31:0] = nv;
                12'hB80: m_cycle[63:32] = nv;
`endif
                default: ;
            endcase
        end
        if (take) begin
            m_epc = pc_value & ~32'h3;
            m_cause = 32'h80000000 | 32'(cause);
            m_mpie = old_mie;
            m_mie = 0;
        end else if (mret) begin
            m_mie = old_mpie;
            m_mpie = 1;
        end
    endfunction

    task automatic push_expected();
        exp_t e;
        ref_alu(ref_op(), alu_in_x, alu_in_y, e.alu, e.zf);
        e.tag  = tag_n++;
        e.csr  = ref_read(bus.csr_address);
        e.pend = ref_pending();
        e.tgt  = ref_target();
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) commit();
        #1;
    endtask

    task automatic quiet();
        bus.csr_write_enable = 0; trap_enter = 0; mret = 0;
        alu_input_selector = 0;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d, input logic [4:0] imm);
        step(); quiet();
        bus.csr_write_enable = 1; bus.csr_address = a; func3 = f3;
        bus.csr_data_in = d; bus.csr_immediate = imm;
        push_expected();
    endtask

    task automatic alu_case(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                            input logic imm, input logic [31:0] x, input logic [31:0] y);
        step(); quiet();
        aluop_in = aop; func3 = f3; func7 = f7; is_immediate = imm;
        alu_in_x = x; alu_in_y = y;
        push_expected();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alu_out", e.tag, alu_out, e.alu);
                check("zero", e.tag, {31'd0, zero}, {31'd0, e.zf});
                check("csr_data_out", e.tag, bus.csr_data_out, e.csr);
                check("interrupt_pending", e.tag, {31'd0, interrupt_pending}, {31'd0, e.pend});
                check("trap_target", e.tag, trap_target, e.tgt);
            end
        end
    end

    initial begin : stimulus
        model_reset();
        bus.csr_write_enable = 0; bus.csr_address = 0; bus.csr_immediate = 0; bus.csr_data_in = 0;
        for (int i = 0; i < 4; i++) begin
            step(); bus.csr_address = addr_tab[i * 2]; push_expected();
        end
        step(); reset = 1;

        alu_case(2'b10, 3'b000, 7'h20, 1'b0, 32'd5, 32'd7);
        alu_case(2'b10, 3'b000, 7'h20, 1'b1, 32'd5, 32'd7);
        alu_case(2'b01, 3'b100, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1);
        alu_case(2'b01, 3'b110, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1);
        alu_case(2'b10, 3'b101, 7'h20, 1'b0, 32'h80000000, 32'd4);
        step(); quiet(); alu_input_selector = 1; control_unit_aluop = 4'd9;
        alu_in_x = 32'hF0F0A5A5; alu_in_y = 32'h3C3CFFFF; push_expected();

        csr_op(12'h340, 3'b001, 32'hDEADBEEF, 5'd0);
        step(); quiet(); push_expected();
        csr_op(12'h340, 3'b111, 32'd0, 5'h0F);
        step(); quiet(); push_expected();

        csr_op(12'h304, 3'b001, 32'h880, 5'd0);
        csr_op(12'h300, 3'b001, 32'h8, 5'd0);
        step(); quiet(); irq_tmr = 1; irq_ext = 1; trap_enter = 1; pc_value = 32'h100;
        bus.csr_address = 12'h344; push_expected();
        step(); quiet(); bus.csr_address = 12'h342; push_expected();
        step(); bus.csr_address = 12'h341; push_expected();
        step(); bus.csr_address = 12'h300; push_expected();
        irq_tmr = 0; irq_ext = 0;

        for (int n = 0; n < 400; n++) begin
            step();
            is_immediate = 1'($urandom); aluop_in = 2'($urandom); func7 = 7'($urandom);
            func3 = 3'($urandom); alu_input_selector = ($urandom_range(0, 3) == 0);
            control_unit_aluop = 4'($urandom);
            alu_in_x = $urandom;
            alu_in_y = ($urandom_range(0, 3) == 0) ? alu_in_x : $urandom;
            bus.csr_write_enable = 1'($urandom);
            bus.csr_address = addr_tab[$urandom_range(0, 16)];
            bus.csr_immediate = 5'($urandom); bus.csr_data_in = $urandom;
            pc_value = $urandom & ~32'h3;
            trap_enter = ($urandom_range(0, 5) == 0); mret = ($urandom_range(0, 9) == 0);
            irq_ext = ($urandom_range(0, 3) == 0); irq_tmr = 1'($urandom);
            irq_sw = ($urandom_range(0, 2) == 0);
            irq_fast = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(1 << $urandom_range(0, 15));
            push_expected();
        end

        csr_op(12'h340, 3'b001, 32'h12345678, 5'd0);
        csr_op(12'h305, 3'b001, 32'h00001001, 5'd0);
        step(); quiet(); irq_ext = 0; irq_tmr = 0; irq_sw = 0; irq_fast = 0;
        reset = 0; model_reset(); bus.csr_address = 12'h340; push_expected();
        step(); bus.csr_address = 12'h305; push_expected();
        step(); bus.csr_address = 12'h300; push_expected();
        step(); reset = 1; bus.csr_address = 12'hB00; push_expected();
        for (int n = 0; n < 6; n++) begin
            step(); bus.csr_address = (n == 5) ? 12'hC80 : 12'hC00; push_expected();
        end

        @(negedge clk); #1;
        check("queue_drained", -1, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
